// File: rtl/orpsoc_boot_pkg.sv
// orpsoc_boot_pkg: shared types and constants for the boot controller
package orpsoc_boot_pkg;
    typedef enum logic [2:0] {IDLE, XFER, RELEASE, RUN, ERR} state_t;
    localparam logic [3:0] WB_SEL_ALL = 4'hf;
    localparam int WORD_BYTES = 4;
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/orpsoc_rst_stagger.sv
// orpsoc_rst_stagger: releases per-core resets one by one, STAGGER cycles apart
// Ports: clk, rst_n (sync, active-low), start (pulse the cycle before release begins),
//        cpu_rst[NUM_CORES] (active-high), all_released (last core out of reset)
module orpsoc_rst_stagger import orpsoc_boot_pkg::*; #(
    parameter int NUM_CORES = 1,
    parameter int STAGGER   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [NUM_CORES-1:0] cpu_rst,
    output logic                 all_released
);
    localparam int LAST = STAGGER * (NUM_CORES - 1);
    localparam int TW   = cnt_w(LAST);
    logic          active;
    logic [TW-1:0] t;
    // t saturates at LAST so released cores stay released until reset
    always_ff @(posedge clk)
        if (!rst_n) begin
            active <= 1'b0;
            t      <= '0;
        end else if (start) begin
            active <= 1'b1;
            t      <= '0;
        end else if (active && int'(t) != LAST)
            t <= t + 1'b1;
    always_comb
        for (int k = 0; k < NUM_CORES; k++)
            cpu_rst[k] = !(active && int'(t) >= STAGGER * k);
    assign all_released = active && int'(t) == LAST;
endmodule

// File: rtl/orpsoc_boot_ctrl.sv
// orpsoc_boot_ctrl: loads a streamed image into RAM over Wishbone, then releases cores
// Ports: wb_clk_i/wb_rst_ni (sync active-low reset), img_* valid/ready word stream,
//        wbm_* Wishbone write master, cpu_rst_o per-core reset, boot_done_o, boot_err_o,
//        words_o words written. Option: ORPSOC_BOOT_CHECKSUM_EN treats the last word as a
//        checksum of all written words instead of data.
module orpsoc_boot_ctrl import orpsoc_boot_pkg::*; #(
    parameter int            NUM_CORES = 1,
    parameter int            AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter int            MAX_WORDS = 16384,
    parameter int            STAGGER   = 16,
    parameter int            TIMEOUT   = 256
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 img_valid_i,
    output logic                 img_ready_o,
    input  logic [31:0]          img_data_i,
    input  logic                 img_last_i,
    output logic [AW-1:0]        wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    output logic [3:0]           wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    output logic [NUM_CORES-1:0] cpu_rst_o,
    output logic                 boot_done_o,
    output logic                 boot_err_o,
    output logic [AW-1:0]        words_o
);
    localparam int TW = cnt_w(TIMEOUT);
    state_t                state, nxt;
    logic                  rdy, last_q, accept, start, all_rel, xfer;
    logic [31:0]           dat_q;
    logic [AW-1:0]         words;
    logic [TW-1:0]         tmo;
    logic [NUM_CORES-1:0]  stg_rst;
`ifdef ORPSOC_BOOT_CHECKSUM_EN
    logic [31:0]           sum;
`endif
    assign accept = img_valid_i && rdy;
    assign xfer   = state == XFER;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:
                if (accept)
`ifdef ORPSOC_BOOT_CHECKSUM_EN
                    nxt = img_last_i ? ((sum == img_data_i) ? RELEASE : ERR)
                                     : (words == AW'(MAX_WORDS)) ? ERR : XFER;
`else
                    nxt = (words == AW'(MAX_WORDS)) ? ERR : XFER;
`endif
            // err wins over a simultaneous ack
            XFER:    nxt = wbm_err_i ? ERR : wbm_ack_i ? (last_q ? RELEASE : IDLE)
                         : (tmo == TW'(TIMEOUT - 1)) ? ERR : XFER;
            RELEASE: nxt = all_rel ? RUN : RELEASE;
            default: nxt = state;
        endcase
    end
    always_ff @(posedge wb_clk_i)
        if (!wb_rst_ni) begin
            state  <= IDLE;
            rdy    <= 1'b0;
            words  <= '0;
            dat_q  <= '0;
            last_q <= 1'b0;
            tmo    <= '0;
`ifdef ORPSOC_BOOT_CHECKSUM_EN
            sum    <= '0;
`endif
        end else begin
            state <= nxt;
            rdy   <= nxt == IDLE;
            tmo   <= xfer ? tmo + 1'b1 : '0;
            if (accept) begin
                dat_q  <= img_data_i;
                last_q <= img_last_i;
            end
            if (xfer && wbm_ack_i && !wbm_err_i) begin
                words <= words + 1'b1;
`ifdef ORPSOC_BOOT_CHECKSUM_EN
                sum   <= sum + dat_q;
`endif
            end
        end
    assign start = (nxt == RELEASE) && (state != RELEASE);
    orpsoc_rst_stagger #(.NUM_CORES(NUM_CORES), .STAGGER(STAGGER)) u_stagger (
        .clk          (wb_clk_i),
        .rst_n        (wb_rst_ni),
        .start        (start),
        .cpu_rst      (stg_rst),
        .all_released (all_rel)
    );
    assign img_ready_o = rdy;
    assign wbm_cyc_o   = xfer;
    assign wbm_stb_o   = xfer;
    assign wbm_we_o    = xfer;
    assign wbm_sel_o   = xfer ? WB_SEL_ALL : '0;
    assign wbm_adr_o   = xfer ? BASE_ADDR + words * AW'(WORD_BYTES) : '0;
    assign wbm_dat_o   = xfer ? dat_q : '0;
    assign cpu_rst_o   = boot_err_o ? '1 : stg_rst;
    assign boot_done_o = state == RUN;
    assign boot_err_o  = state == ERR;
    assign words_o     = words;
endmodule
